// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg - shared types and constants for the parametrised UART transmitter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int C_PARITY_EVEN   = 0;
  localparam int C_PARITY_ODD    = 1;

  localparam int C_STOP_BITS_ONE = 1;
  localparam int C_STOP_BITS_TWO = 2;

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ----------------------------------------------------------------------------
// uart_baud_tick - per-bit cycle counter; o_bit_end marks the last cycle of a bit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic tx_clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_bit_end
);

  localparam int              C_W    = $clog2(CLKS_PER_BIT);
  localparam logic [C_W-1:0]  C_LAST = C_W'(CLKS_PER_BIT - 1);

  logic [C_W-1:0] r_count;

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear || o_bit_end) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_bit_end = (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx_frame.sv
// ----------------------------------------------------------------------------
// uart_tx_frame - parametrised LSB-first UART transmitter (parity via UART_TX_PARITY_EN)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = C_STOP_BITS_ONE,
  parameter int PARITY_ODD   = C_PARITY_EVEN
) (
  input  logic                 tx_clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 data_out,
  output logic                 busy,
  output logic                 done
);

  localparam int                 C_CNT_W     = $clog2(DATA_BITS + 1);
  localparam logic [C_CNT_W-1:0] C_LAST_DATA = C_CNT_W'(DATA_BITS - 1);
  localparam logic [C_CNT_W-1:0] C_LAST_STOP = C_CNT_W'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
  localparam tx_state_t          C_AFTER_DATA = ST_PARITY;
`else
  localparam tx_state_t          C_AFTER_DATA = ST_STOP;
`endif

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 ||
        (STOP_BITS != C_STOP_BITS_ONE && STOP_BITS != C_STOP_BITS_TWO) ||
        (PARITY_ODD != C_PARITY_EVEN && PARITY_ODD != C_PARITY_ODD)) begin : g_bad_params
      $error("uart_tx_frame: illegal parameter value");
    end
  endgenerate

  tx_state_t            r_state;
  tx_state_t            w_state_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [C_CNT_W-1:0]   r_bit_cnt;
  logic [C_CNT_W-1:0]   w_bit_cnt_next;
  logic                 r_data_out;
  logic                 r_done;
  logic                 w_data_out_next;
  logic                 w_done_next;
  logic                 w_bit_end;
  logic                 w_baud_clear;
  logic                 w_accept;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  assign w_accept     = tx_valid && (r_state == ST_IDLE);
  // Holding the counter clear through IDLE makes every bit start at a fresh count.
  assign w_baud_clear = (r_state == ST_IDLE) || (w_state_next != r_state);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .tx_clk    (tx_clk),
    .rst       (rst),
    .i_clear   (w_baud_clear),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (tx_valid)                                   w_state_next = ST_START;
      ST_START:  if (w_bit_end)                                  w_state_next = ST_DATA;
      ST_DATA:   if (w_bit_end && (r_bit_cnt == C_LAST_DATA))    w_state_next = C_AFTER_DATA;
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (w_bit_end)                                  w_state_next = ST_STOP;
`endif
      ST_STOP:   if (w_bit_end && (r_bit_cnt == C_LAST_STOP))    w_state_next = ST_IDLE;
      default:                                                   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    if (w_accept) begin
      w_shift_next = tx_data;
    end else if ((r_state == ST_DATA) && w_bit_end) begin
      w_shift_next = r_shift >> 1;
    end
    if (w_state_next != r_state) begin
      w_bit_cnt_next = '0;
    end else if (w_bit_end && (r_state != ST_IDLE)) begin
      w_bit_cnt_next = r_bit_cnt + 1'b1;
    end
  end

  // Outputs are decoded from the next state so the registered line changes on the entry edge.
  always_comb begin
    w_done_next = (r_state == ST_STOP) && (w_state_next == ST_IDLE);
    case (w_state_next)
      ST_START:  w_data_out_next = 1'b0;
      ST_DATA:   w_data_out_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_data_out_next = r_parity;
`endif
      default:   w_data_out_next = 1'b1;
    endcase
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_data_out <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_data_out <= w_data_out_next;
      r_done     <= w_done_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= (^tx_data) ^ (PARITY_ODD != C_PARITY_EVEN);
    end
  end
`endif

  assign data_out = r_data_out;
  assign done     = r_done;
  assign tx_ready = (r_state == ST_IDLE);
  assign busy     = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_frame - self-checking bench for uart_tx_frame (honours UART_TX_PARITY_EN)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_frame;

  localparam int CPB  = 4;
  localparam int DB_A = 8;
  localparam int SB_A = 1;
  localparam int PO_A = 0;
  localparam int DB_B = 5;
  localparam int SB_B = 2;
  localparam int PO_B = 1;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int N_A = 1 + DB_A + P + SB_A;
  localparam int N_B = 1 + DB_B + P + SB_B;

  logic       tx_clk = 1'b0;
  logic       rst    = 1'b1;
  logic       va, vb;
  logic [7:0] da;
  logic [4:0] db;
  logic       ready_a, line_a, busy_a, done_a;
  logic       ready_b, line_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_a;
  logic [15:0] exp_b;

  always #5 tx_clk = ~tx_clk;

  uart_tx_frame #(
    .DATA_BITS (DB_A), .CLKS_PER_BIT (CPB), .STOP_BITS (SB_A), .PARITY_ODD (PO_A)
  ) u_dut_a (
    .tx_clk (tx_clk), .rst (rst), .tx_valid (va), .tx_ready (ready_a),
    .tx_data (da), .data_out (line_a), .busy (busy_a), .done (done_a)
  );

  uart_tx_frame #(
    .DATA_BITS (DB_B), .CLKS_PER_BIT (CPB), .STOP_BITS (SB_B), .PARITY_ODD (PO_B)
  ) u_dut_b (
    .tx_clk (tx_clk), .rst (rst), .tx_valid (vb), .tx_ready (ready_b),
    .tx_data (db), .data_out (line_b), .busy (busy_b), .done (done_b)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model for DUT A: one queue entry per expected line cycle.
  bit mq[$];
  bit fb[$];
  bit m_dout = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_ready = 1'b1, m_pend = 1'b0;

  initial begin : model
    forever begin
      @(posedge tx_clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_dout = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_ready = 1'b1; m_pend = 1'b0;
      end else if (mq.size() > 0) begin
        m_dout = mq.pop_front(); m_busy = 1'b1; m_ready = 1'b0; m_done = 1'b0;
        if (mq.size() == 0) m_pend = 1'b1;
      end else if (m_pend) begin
        m_pend = 1'b0;
        m_dout = 1'b1; m_busy = 1'b0; m_done = 1'b1; m_ready = 1'b1;
      end else if (va && m_ready) begin
        fb.delete();
        fb.push_back(1'b0);
        for (int i = 0; i < DB_A; i++) fb.push_back(da[i]);
`ifdef UART_TX_PARITY_EN
        fb.push_back((^da) ^ (PO_A != 0));
`endif
        for (int i = 0; i < SB_A; i++) fb.push_back(1'b1);
        foreach (fb[j]) repeat (CPB) mq.push_back(fb[j]);
        m_dout = mq.pop_front(); m_busy = 1'b1; m_ready = 1'b0; m_done = 1'b0;
      end else begin
        m_dout = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_ready = 1'b1;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge tx_clk);
      if (!rst) begin
        check("model_line",  line_a,  m_dout);
        check("model_busy",  busy_a,  m_busy);
        check("model_done",  done_a,  m_done);
        check("model_ready", ready_a, m_ready);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
`ifdef UART_TX_PARITY_EN
    exp_a = 16'(11'b10101001010);
    exp_b = 16'(9'b110100110);
`else
    exp_a = 16'(10'b1101001010);
    exp_b = 16'(8'b11100110);
`endif
    va = 1'b0; vb = 1'b0; da = 8'h00; db = 5'h00;
    repeat (3) @(posedge tx_clk);
    #1 rst = 1'b0;

    @(negedge tx_clk);
    check("reset_line",  line_a,  1'b1);
    check("reset_busy",  busy_a,  1'b0);
    check("reset_done",  done_a,  1'b0);
    check("reset_ready", ready_a, 1'b1);

    // Single 0xA5 frame against literal bit pattern
    @(posedge tx_clk); #1 va = 1'b1; da = 8'hA5;
    @(posedge tx_clk); #1 va = 1'b0;
    for (int k = 1; k <= N_A * CPB + 1; k++) begin
      @(negedge tx_clk);
      if (k <= N_A * CPB) begin
        check("a5_line", line_a, exp_a[(k - 1) / CPB]);
        check("a5_busy", busy_a, 1'b1);
        check("a5_done", done_a, 1'b0);
      end else begin
        check("a5_done_end",  done_a,  1'b1);
        check("a5_busy_end",  busy_a,  1'b0);
        check("a5_ready_end", ready_a, 1'b1);
      end
    end

    // Back-to-back 0x00 then 0xFF with tx_valid held
    @(posedge tx_clk); #1 va = 1'b1; da = 8'h00;
    @(posedge tx_clk); #1 da = 8'hFF;
    for (int k = 1; k <= N_A * CPB + 2; k++) begin
      @(negedge tx_clk);
      if (k == 1)            check("b2b_start1", line_a, 1'b0);
      if (k == N_A * CPB)    check("b2b_stop1",  line_a, 1'b1);
      if (k == N_A * CPB + 1) begin
        check("b2b_gap_line", line_a, 1'b1);
        check("b2b_gap_done", done_a, 1'b1);
      end
      if (k == N_A * CPB + 2) begin
        check("b2b_start2", line_a, 1'b0);
        check("b2b_busy2",  busy_a, 1'b1);
      end
    end
    #1 va = 1'b0; da = 8'h3C;
    repeat (N_A * CPB + 3) @(posedge tx_clk);

    // tx_valid pulsed mid-frame must be ignored
    @(posedge tx_clk); #1 va = 1'b1; da = 8'h5A;
    @(posedge tx_clk); #1 va = 1'b0;
    repeat (9) @(posedge tx_clk);
    #1 va = 1'b1; da = 8'hFF;
    @(posedge tx_clk); #1 va = 1'b0;
    repeat (N_A * CPB + 1 - 11) @(posedge tx_clk);
    @(negedge tx_clk);
    check("pulse_done",     done_a, 1'b1);
    @(negedge tx_clk);
    check("pulse_noaccept", busy_a, 1'b0);
    repeat (3) @(posedge tx_clk);

    // Asynchronous reset in cycle 15 of a 0x00 frame
    @(posedge tx_clk); #1 va = 1'b1; da = 8'h00;
    @(posedge tx_clk); #1 va = 1'b0;
    repeat (14) @(posedge tx_clk);
    @(negedge tx_clk);
    check("rst_pre_line", line_a, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("rst_async_line",  line_a,  1'b1);
    check("rst_async_busy",  busy_a,  1'b0);
    check("rst_async_done",  done_a,  1'b0);
    check("rst_async_ready", ready_a, 1'b1);
    @(posedge tx_clk);
    @(negedge tx_clk);
    #1 rst = 1'b0; va = 1'b1; da = 8'hC3;
    @(posedge tx_clk); #1 va = 1'b0;
    @(negedge tx_clk);
    check("post_rst_busy", busy_a, 1'b1);
    check("post_rst_line", line_a, 1'b0);
    repeat (N_A * CPB + 3) @(posedge tx_clk);

    // DUT B: 5 data bits, 2 stop bits, 0x13
    @(posedge tx_clk); #1 vb = 1'b1; db = 5'h13;
    @(posedge tx_clk); #1 vb = 1'b0; db = 5'h0C;
    for (int k = 1; k <= N_B * CPB + 1; k++) begin
      @(negedge tx_clk);
      if (k <= N_B * CPB) begin
        check("b13_line", line_b, exp_b[(k - 1) / CPB]);
        check("b13_busy", busy_b, 1'b1);
        check("b13_done", done_b, 1'b0);
      end else begin
        check("b13_done_end",  done_b,  1'b1);
        check("b13_line_end",  line_b,  1'b1);
        check("b13_ready_end", ready_b, 1'b1);
      end
    end
    repeat (3) @(posedge tx_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter, the successor to the fixed 8N1 transmitter in the UART block. It accepts one character per valid/ready handshake and serialises it LSB-first. Each bit is held for a configurable number of clock cycles. Data width and stop-bit count are configurable, and an optional parity bit can be compiled in. It sits between the host-side byte source and the serial TX pin.

## Interface
Parameters:
- DATA_BITS, default 8: data bits per frame; legal range 5..9.
- CLKS_PER_BIT, default 16: tx_clk cycles per serial bit; must be ≥ 2.
- STOP_BITS, default 1: 1 or 2.
- PARITY_ODD, default 0: 0 = even, 1 = odd. Used only when UART_TX_PARITY_EN is defined.

Ports:
- tx_clk  in  1  single clock for the whole block.
- rst  in  1  reset; asynchronous, active-high.
- tx_valid  in  1  a character is offered on tx_data.
- tx_ready  out  1  block can accept a character; high exactly when the state is IDLE.
- tx_data  in  DATA_BITS  character; sampled only on the accepting edge.
- data_out  out  1  serial line; idles high.
- busy  out  1  high from the first start-bit cycle through the last stop-bit cycle.
- done  out  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Reset, applied asynchronously:
  - state=IDLE, data_out=1, busy=0, done=0, tx_ready=1.
  - Shift register, bit counter and baud counter are cleared.
- IDLE:
  - data_out=1.
  - Acceptance = tx_valid & tx_ready at a tx_clk edge.
  - On acceptance, tx_data is latched into the shift register and the state goes to START.
- Bit timing: a baud counter counts 0..CLKS_PER_BIT-1 and is cleared on every state entry. Each bit is driven for exactly CLKS_PER_BIT cycles.
- START: data_out=0.
- DATA:
  - data_out = shift[0]; the register shifts right at each bit boundary.
  - The bit counter (width $clog2(DATA_BITS+1)) runs 0..DATA_BITS-1, then the state advances.
- PARITY: data_out = XOR(latched data) ^ PARITY_ODD.
- STOP:
  - data_out=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - The state then returns to IDLE with done=1 for that single cycle.
- busy = (state != IDLE).
- tx_valid while busy is ignored. tx_data changes mid-frame do not affect the frame.

## Timing
- Frame length N = 1 + DATA_BITS + P + STOP_BITS bits, where P = 1 with parity, else 0.
- Cycle-level sequence, with acceptance at edge E0:
  - data_out falls in the cycle after E0.
  - busy rises in that same cycle.
  - The line is held for N×CLKS_PER_BIT cycles.
  - done and tx_ready are high in cycle E0 + N×CLKS_PER_BIT + 1.
- Back-to-back (tx_valid held high):
  - The next acceptance occurs at the edge ending the done cycle.
  - Frame period is N×CLKS_PER_BIT + 1 cycles, with exactly one extra idle-high cycle between frames.
- Reset mid-frame:
  - data_out goes to 1 immediately, without waiting for a clock.
  - The frame is abandoned and no done pulse is produced.
  - After release, tx_ready=1 and a new acceptance is possible on the first edge.
- All outputs are registered, except tx_ready and busy, which are decoded from the state register.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: the PARITY state exists and a parity bit is inserted between the data and stop bits, per PARITY_ODD.
  - Undefined: the PARITY state and parity logic are not built, DATA goes directly to STOP, and PARITY_ODD is ignored.

## Structure
- Package uart_pkg holds:
  - the tx state enum typedef (IDLE, START, DATA, PARITY, STOP);
  - the PARITY_EVEN/PARITY_ODD constants;
  - the STOP_BITS legal-value constants.
- One sub-module, uart_baud_tick:
  - a CLKS_PER_BIT counter with a synchronous clear input (pulsed on state entry);
  - one output, bit_end, high on the last cycle of the bit.

## Test plan
- 8N1 frame: DATA_BITS=8, CLKS_PER_BIT=4, send 0xA5 → line bits 0,1,0,1,0,0,1,0,1,1, each exactly 4 cycles wide; done pulses in cycle 41 after acceptance; busy is high for cycles 1..40.
- Parity (macro defined), 0xA5 (four ones) → parity bit 0 with PARITY_ODD=0 and 1 with PARITY_ODD=1; frame is 44 cycles at CLKS_PER_BIT=4.
- Back-to-back 0x00 then 0xFF with tx_valid held → second start bit begins 41 cycles after the first; exactly one idle-high cycle between frames; tx_data changed mid-frame is ignored.
- STOP_BITS=2, DATA_BITS=5, send 0x13 → bits 0,1,1,0,0,1,1,1, each 4 cycles wide.
- Reset at cycle 15 of a 0x00 frame → data_out=1 before the next edge; no done pulse; tx_ready=1; the next frame after release is correct.
- tx_valid pulsed while busy → no acceptance and no frame corruption.
